// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// wb_port_arbiter: shares the register-file write port between the WB stage
// and a FIFO of multi-cycle-unit results. The pipeline has priority, and a
// starvation counter drains the FIFO.
// Optional feature: WB_ARB_BYPASS_EN (an MCU result skips an idle, empty FIFO).
// Rev 1.0
// ============================================================================
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid_in,
  input  logic [4:0]  pipe_rd_in,
  input  logic [31:0] pipe_data_in,
  input  logic        mcu_valid_in,
  input  logic [4:0]  mcu_rd_in,
  input  logic [31:0] mcu_data_in,
  output logic        mcu_ready_out,
  output logic        pipe_stall_out,
  output logic        rf_we_out,
  output logic [4:0]  rf_waddr_out,
  output logic [31:0] rf_wdata_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

  logic [36:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_rf_we;
  logic [4:0]    r_rf_waddr;
  logic [31:0]   r_rf_wdata;

  logic          w_nonempty;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_grant;
  logic [4:0]    w_rd;
  logic [31:0]   w_data;

  // Both flow-control outputs come purely from registered state.
  assign w_nonempty     = (r_count != '0);
  assign mcu_ready_out  = (r_count < C_DEPTH);
  assign pipe_stall_out = w_nonempty && (r_starve == C_STARVE_MAX);

`ifdef WB_ARB_BYPASS_EN
  assign w_bypass = mcu_valid_in && !w_nonempty && !pipe_valid_in && !pipe_stall_out;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = mcu_valid_in && mcu_ready_out && !w_bypass;

  always_comb begin
    w_pop   = 1'b0;
    w_grant = 1'b0;
    w_rd    = r_mem[r_rptr][36:32];
    w_data  = r_mem[r_rptr][31:0];
    if (pipe_stall_out) begin
      w_pop   = 1'b1;
      w_grant = 1'b1;
    end else if (pipe_valid_in) begin
      w_grant = 1'b1;
      w_rd    = pipe_rd_in;
      w_data  = pipe_data_in;
    end else if (w_nonempty) begin
      w_pop   = 1'b1;
      w_grant = 1'b1;
    end else if (w_bypass) begin
      w_grant = 1'b1;
      w_rd    = mcu_rd_in;
      w_data  = mcu_data_in;
    end
  end

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {mcu_rd_in, mcu_data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop || !w_nonempty) begin
        r_starve <= '0;
      end else if (r_starve != C_STARVE_MAX) begin
        r_starve <= r_starve + 1'b1;
      end

      // x0 results are consumed normally but never reach the register file.
      if (w_grant) begin
        r_rf_we    <= (w_rd != 5'd0);
        r_rf_waddr <= w_rd;
        r_rf_wdata <= w_data;
      end else begin
        r_rf_we    <= 1'b0;
      end
    end
  end

  assign rf_we_out    = r_rf_we;
  assign rf_waddr_out = r_rf_waddr;
  assign rf_wdata_out = r_rf_wdata;

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline write-back result (output of the WB source mux) and results from a multi-cycle unit (MCU, e.g. iterative mul/div).
- MCU results are queued in a small FIFO. The pipeline has priority. A starvation counter forces a one-cycle pipeline stall so that the FIFO drains.
- Sits between the WB stage / MCU and the register file write port. RF write outputs are registered.

Parameters:
- DEPTH, 2, MCU result FIFO entries (power of 2, ≥2)
- STARVE_MAX, 4, cycles a non-empty FIFO head may wait before the pipeline is stalled (≥1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- pipe_valid_in  input  1  pipeline WB stage holds a result to write
- pipe_rd_in  input  5  pipeline destination register
- pipe_data_in  input  32  pipeline write data (WB mux output)
- mcu_valid_in  input  1  MCU result valid
- mcu_rd_in  input  5  MCU destination register
- mcu_data_in  input  32  MCU result data
- mcu_ready_out  output  1  FIFO can accept an MCU result
- pipe_stall_out  output  1  hold the WB stage; pipeline result not consumed this cycle
- rf_we_out  output  1  register-file write enable (registered)
- rf_waddr_out  output  5  register-file write address (registered)
- rf_wdata_out  output  32  register-file write data (registered)

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - rf_we_out=0, rf_waddr_out=0, rf_wdata_out=0.
  - FIFO empty (count=0, pointers=0), starve_cnt=0.
  - Hence mcu_ready_out=1 and pipe_stall_out=0.
  - A reset asserted mid-operation discards all queued MCU results.
- MCU push: occurs when mcu_valid_in && mcu_ready_out.
  - mcu_ready_out = (count < DEPTH). It depends only on registered state.
  - When the FIFO is full, a same-cycle pop does not re-enable ready.
  - The MCU holds valid, rd and data stable until accepted.
- pipe_stall_out = (count != 0) && (starve_cnt == STARVE_MAX). It depends only on registered state.
- Grant, evaluated each cycle in priority order:
  - 1) pipe_stall_out=1: pop FIFO head and write it.
  - 2) pipe_valid_in=1: write the pipeline result (consumed).
  - 3) count != 0: pop FIFO head and write it.
  - 4) otherwise idle.
- Write register update at the next edge:
  - On a grant: rf_we_out = (granted rd != 0), rf_waddr_out = granted rd, rf_wdata_out = granted data.
  - On idle: rf_we_out=0; address and data hold their previous values.
- x0 handling: a write to x0 is consumed or popped normally, but rf_we_out=0.
- Latency:
  - Pipeline result → RF write: 1 cycle.
  - MCU result (empty FIFO, no pipe traffic): accepted at cycle N, popped at N+1, rf_we_out high at N+2.
- starve_cnt:
  - Cleared on any FIFO pop, and whenever count==0.
  - Otherwise increments by 1 per cycle while count != 0, saturating at STARVE_MAX.
- Simultaneous push and pop in the same cycle: count is unchanged and pointers advance independently.
- FIFO wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Order is strictly FIFO.
- Ordering between a pipeline write and an MCU write to the same rd is the issue logic's responsibility. This block never reorders results within the MCU stream.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- Defined: when count==0 and pipe_valid_in=0 and pipe_stall_out=0, an accepted MCU result bypasses the FIFO. It is written directly at the next edge (latency 1) and is not pushed.
- Not defined: every MCU result goes through the FIFO (latency ≥2).
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst for 2 cycles mid-traffic with the FIFO holding 2 entries → rf_we_out=0, mcu_ready_out=1, pipe_stall_out=0; no queued entry is ever written.
- Pipeline only: pipe_valid_in=1, rd=5, data=0xDEADBEEF → next cycle rf_we_out=1, rf_waddr_out=5, rf_wdata_out=0xDEADBEEF; with rd=0 → rf_we_out=0.
- MCU idle path: single MCU push of rd=7, data=0x12 with no pipe traffic → RF write at N+2; with WB_ARB_BYPASS_EN, at N+1.
- Full FIFO: push rd=1 and rd=2 while pipe_valid_in=1 continuously → mcu_ready_out=0 after 2 pushes; a third mcu_valid_in is held and not accepted.
- Starvation: FIFO non-empty, pipe_valid_in=1 every cycle, STARVE_MAX=4 → pipe_stall_out=1 in the 5th cycle, the head (rd=1) is written, the pipeline result is written on the following non-stalled cycle, and starve_cnt restarts.
- Order and wrap-around: 6 MCU results rd=1..6 interleaved with idle cycles → RF writes occur in order 1..6 with matching data; count never exceeds DEPTH.
